// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants (640x480@60 defaults), receiver counter limits
// and the receiver FSM state type. The display generator uses the same package.
package vga_timing_pkg;

    localparam int H_SYNC_DEF   = 96;
    localparam int H_BACK_DEF   = 48;
    localparam int H_ACTIVE_DEF = 640;
    localparam int H_TOTAL_DEF  = 800;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BACK_DEF   = 33;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_TOTAL_DEF  = 525;

    localparam int H_CNT_W = 11;
    localparam int V_CNT_W = 10;

    localparam logic [H_CNT_W-1:0] H_CNT_MAX = 11'd2047;
    localparam logic [V_CNT_W-1:0] V_CNT_MAX = 10'd1023;

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2
    } rx_state_e;

endpackage

// File: rtl/vga_edge_det.sv
// Registers one sync input and flags its falling edge. Both flops reset high,
// so an input that is already low when reset releases produces one edge.
module vga_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic sig_in,
    output logic fall
);

    logic sig_q, sig_d;
    logic prev_q, prev_d;

    // next-state: capture the pin, keep the previous registered copy
    always_comb begin
        sig_d  = sig_in;
        prev_d = sig_q;
    end

    // input and history registers
    always_ff @(posedge clk) begin
        if (rst) begin
            sig_q  <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            sig_q  <= sig_d;
            prev_q <= prev_d;
        end
    end

    assign fall = prev_q & ~sig_q;

endmodule

// File: rtl/vga_sync_rx.sv
// VGA sync receiver: recovers pixel coordinates from hs/vs, checks the line
// and frame timing against the parameters and strobes active pixels once locked.
// Optional build macro: VGA_SYNC_RX_SUM_EN enables the per-frame pixel checksum.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_SEARCH  | waiting for a vs falling edge, no checking
// ST_MEASURE | one full frame of line/frame length checks before locking
// ST_LOCKED  | timing verified, pixels delivered, violations pulse err_pulse
module vga_sync_rx
    import vga_timing_pkg::*;
#(
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BACK   = H_BACK_DEF,
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_TOTAL  = H_TOTAL_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BACK   = V_BACK_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_TOTAL  = V_TOTAL_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vga_hs,
    input  logic        vga_vs,
    input  logic [7:0]  vga_rgb,
    output logic        pix_valid,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic [7:0]  pix_data,
    output logic        frame_start,
    output logic        locked,
    output logic        err_pulse,
    output logic [15:0] frame_sum
);

    localparam logic [H_CNT_W-1:0] H_START  = H_CNT_W'(H_SYNC + H_BACK);
    localparam logic [H_CNT_W-1:0] H_END    = H_CNT_W'(H_SYNC + H_BACK + H_ACTIVE - 1);
    localparam logic [H_CNT_W-1:0] H_LEN_OK = H_CNT_W'(H_TOTAL - 1);
    localparam logic [V_CNT_W-1:0] V_START  = V_CNT_W'(V_SYNC + V_BACK);
    localparam logic [V_CNT_W-1:0] V_END    = V_CNT_W'(V_SYNC + V_BACK + V_ACTIVE - 1);
    localparam logic [V_CNT_W-1:0] V_LEN_OK = V_CNT_W'(V_TOTAL - 1);

    logic hs_fall, vs_fall;

    vga_edge_det u_hs_edge (
        .clk    (clk),
        .rst    (rst),
        .sig_in (vga_hs),
        .fall   (hs_fall)
    );

    vga_edge_det u_vs_edge (
        .clk    (clk),
        .rst    (rst),
        .sig_in (vga_vs),
        .fall   (vs_fall)
    );

    logic [7:0]         rgb_q, rgb_d;
    logic [H_CNT_W-1:0] h_cnt_q, h_cnt_d;
    logic [V_CNT_W-1:0] v_cnt_q, v_cnt_d;
    logic               hs_seen_q, hs_seen_d;
    rx_state_e          state_q, state_d;
    logic               err_q, err_d;
    logic               pix_valid_q, pix_valid_d;
    logic [9:0]         pix_x_q, pix_x_d;
    logic [9:0]         pix_y_q, pix_y_d;
    logic [7:0]         pix_data_q, pix_data_d;
    logic               frame_start_q, frame_start_d;

    logic line_bad, frame_bad, h_sat, timing_bad;
    logic active;

    // position counters; h_cnt_d/v_cnt_d describe the pixel currently in rgb_q
    always_comb begin
        rgb_d = vga_rgb;

        h_cnt_d = h_cnt_q;
        if (hs_fall) begin
            h_cnt_d = '0;
        end else if (h_cnt_q != H_CNT_MAX) begin
            h_cnt_d = h_cnt_q + 1'b1;
        end

        v_cnt_d = v_cnt_q;
        if (vs_fall) begin
            v_cnt_d = '0;
        end else if (hs_fall && (v_cnt_q != V_CNT_MAX)) begin
            v_cnt_d = v_cnt_q + 1'b1;
        end

        hs_seen_d = hs_seen_q | hs_fall;
    end

    // timing checks; a line is only measured once a previous hs edge was seen
    always_comb begin
        line_bad   = hs_fall && hs_seen_q && (h_cnt_q != H_LEN_OK);
        frame_bad  = vs_fall ? (v_cnt_q != V_LEN_OK)
                             : (hs_fall && (v_cnt_q == V_LEN_OK));
        h_sat      = (h_cnt_q == H_CNT_MAX);
        timing_bad = line_bad | frame_bad | h_sat;
    end

    // lock FSM next-state and error pulse
    always_comb begin
        state_d = state_q;
        err_d   = 1'b0;
        case (state_q)
            ST_SEARCH: begin
                if (vs_fall) state_d = ST_MEASURE;
            end
            ST_MEASURE: begin
                if (timing_bad)   state_d = ST_SEARCH;
                else if (vs_fall) state_d = ST_LOCKED;
            end
            ST_LOCKED: begin
                if (timing_bad) begin
                    state_d = ST_SEARCH;
                    err_d   = 1'b1;
                end
            end
            default: state_d = ST_SEARCH;
        endcase
    end

    // pixel outputs; gated by next state so they drop together with locked
    always_comb begin
        active = (h_cnt_d >= H_START) && (h_cnt_d <= H_END) &&
                 (v_cnt_d >= V_START) && (v_cnt_d <= V_END) &&
                 (state_d == ST_LOCKED);
        pix_valid_d   = active;
        pix_data_d    = pix_data_q;
        pix_x_d       = pix_x_q;
        pix_y_d       = pix_y_q;
        frame_start_d = active && (h_cnt_d == H_START) && (v_cnt_d == V_START);
        if (active) begin
            pix_data_d = rgb_q;
            pix_x_d    = 10'(h_cnt_d - H_START);
            pix_y_d    = 10'(v_cnt_d - V_START);
        end
    end

    // all state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_q         <= '0;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            hs_seen_q     <= 1'b0;
            state_q       <= ST_SEARCH;
            err_q         <= 1'b0;
            pix_valid_q   <= 1'b0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            pix_data_q    <= '0;
            frame_start_q <= 1'b0;
        end else begin
            rgb_q         <= rgb_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            hs_seen_q     <= hs_seen_d;
            state_q       <= state_d;
            err_q         <= err_d;
            pix_valid_q   <= pix_valid_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            pix_data_q    <= pix_data_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign pix_valid   = pix_valid_q;
    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign pix_data    = pix_data_q;
    assign frame_start = frame_start_q;
    assign err_pulse   = err_q;
    assign locked      = (state_q == ST_LOCKED);

`ifdef VGA_SYNC_RX_SUM_EN
    localparam logic [9:0] H_LAST = 10'(H_ACTIVE - 1);
    localparam logic [9:0] V_LAST = 10'(V_ACTIVE - 1);

    logic [15:0] sum_acc_q, sum_acc_d;
    logic [15:0] frame_sum_q, frame_sum_d;

    // running sum restarts at pixel (0,0); result published after the last pixel
    always_comb begin
        sum_acc_d   = sum_acc_q;
        frame_sum_d = frame_sum_q;
        if (pix_valid_q) begin
            if (frame_start_q) begin
                sum_acc_d = {8'h00, pix_data_q};
            end else begin
                sum_acc_d = sum_acc_q + {8'h00, pix_data_q};
            end
            if ((pix_x_q == H_LAST) && (pix_y_q == V_LAST)) begin
                frame_sum_d = sum_acc_d;
            end
        end
    end

    // checksum registers
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_acc_q   <= '0;
            frame_sum_q <= '0;
        end else begin
            sum_acc_q   <= sum_acc_d;
            frame_sum_q <= frame_sum_d;
        end
    end

    assign frame_sum = frame_sum_q;
`else
    assign frame_sum = '0;
`endif

endmodule

// File: doc/vga_sync_rx.md
VGA_SYNC_RX -- requirements
Module: vga_sync_rx

Interface
REQ-001 Parameter H_SYNC, 96, HS low width in clocks.
REQ-002 Parameter H_BACK, 48, HS back porch in clocks.
REQ-003 Parameter H_ACTIVE, 640, active pixels per line.
REQ-004 Parameter H_TOTAL, 800, clocks per line.
REQ-005 Parameter V_SYNC, 2, VS low width in lines.
REQ-006 Parameter V_BACK, 33, VS back porch in lines.
REQ-007 Parameter V_ACTIVE, 480, active lines per frame.
REQ-008 Parameter V_TOTAL, 525, lines per frame.
REQ-009 clk  in  1  pixel clock; single clock domain, rising edge.
REQ-010 rst  in  1  synchronous, active-high reset.
REQ-011 vga_hs  in  1  horizontal sync, active low.
REQ-012 vga_vs  in  1  vertical sync, active low.
REQ-013 vga_rgb  in  8  pixel data.
REQ-014 pix_valid  out  1  active-area pixel strobe, only while locked.
REQ-015 pix_x, pix_y  out  10 each  coordinates of current pixel.
REQ-016 pix_data  out  8  captured pixel.
REQ-017 frame_start  out  1  one-cycle pulse with pixel (0,0).
REQ-018 locked  out  1  timing matches parameters.
REQ-019 err_pulse  out  1  one-cycle pulse on timing violation.
REQ-020 frame_sum  out  16  per-frame pixel checksum (see Configuration).

Function
REQ-021 Inputs SHALL be registered once; hs/vs falling edge detected from registered copy versus its previous value.
REQ-022 h_cnt SHALL load 0 on hs falling edge, else increment, saturating at 2047.
REQ-023 v_cnt SHALL load 0 on vs falling edge, else increment on hs falling edge, saturating at 1023; vs edge wins when simultaneous with hs edge.
REQ-024 Active region: h_cnt in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_ACTIVE-1] and v_cnt in [V_SYNC+V_BACK, V_SYNC+V_BACK+V_ACTIVE-1].
REQ-025 pix_x/pix_y SHALL equal h_cnt/v_cnt minus porch offsets; all pix_* registered; rgb sampled at pin cycle N appears on pix_data at cycle N+2 with matching pix_valid.
REQ-026 FSM states SEARCH, MEASURE, LOCKED; SEARCH->MEASURE on vs falling edge.
REQ-027 MEASURE: every hs-to-hs length SHALL equal H_TOTAL and next vs-to-vs line count SHALL equal V_TOTAL; all match -> LOCKED, any mismatch -> SEARCH (no err_pulse).
REQ-028 LOCKED: line length != H_TOTAL, frame line count != V_TOTAL, or h_cnt saturation (sync loss) SHALL pulse err_pulse one cycle and go to SEARCH; locked deasserts same cycle.
REQ-029 pix_valid and frame_start SHALL be 0 outside LOCKED; a frame in progress when lock drops is truncated.
REQ-030 First line after vs edge SHALL not be length-checked if preceded by partial line (check only between two observed hs edges).

Reset
REQ-031 rst SHALL clear counters, edge registers (treated as high), FSM to SEARCH, all outputs to 0.
REQ-032 rst asserted mid-frame SHALL abort immediately; relock requires a full MEASURE frame.

Configuration
REQ-033 Macro VGA_SYNC_RX_SUM_EN: defined -> frame_sum = 16-bit wrapping sum of pix_data over all valid pixels of frame, updated on the cycle after last active pixel, held otherwise.
REQ-034 Undefined -> no accumulator logic; frame_sum tied to 0.

Structure
REQ-035 Package vga_timing_pkg SHALL hold default 640x480@60 timing constants and FSM state enum, shared with the display generator.
REQ-036 One sub-module vga_edge_det (register plus falling-edge pulse), instantiated for hs and vs.

Verification
REQ-037 Drive with top_vga_disp default timing, 20 ns clock -> locked=1 after second vs edge; frame_start once per 420000 clocks.
REQ-038 Known pattern rgb=x[7:0] -> pix_data at (x,y) equals x[7:0], 307200 pix_valid per frame, pix_x 0..639.
REQ-039 Stretch one line to 801 clocks while locked -> single err_pulse, locked=0, relock after two more clean frames.
REQ-040 Hold vga_hs high 3000 clocks while locked -> err_pulse at h_cnt saturation, state SEARCH.
REQ-041 rst asserted at pixel (320,240) -> all outputs 0 next cycle, no pix_valid until relocked.
REQ-042 SUM_EN defined, constant rgb=8'h01 -> frame_sum = 307200 mod 65536 = 16'hB000; undefined -> frame_sum=0.
